// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the byte-addressed data memory: access-size
// encoding, FSM states, response pipeline stage, byte-lane and alignment logic.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    // Access size encoding on req_size; 2'd3 is reserved and always errors.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_e;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One slot of the response pipeline; word is the raw memory word read
    // at acceptance, aligned and extended only at the final stage.
    typedef struct packed {
        logic        valid;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  ofs;
        logic        err;
        logic [31:0] word;
    } stage_t;

    // Misalignment (or illegal size) for a given size and byte offset.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = ofs[0];
            SIZE_W:  bad = (ofs != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << ofs;
            SIZE_H:  be = ofs[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the low-order store data across all lanes so any enabled
    // lane picks up the right bytes without a shifter.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SIZE_B:  d = {4{wdata[7:0]}};
            SIZE_H:  d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_load_align.sv
//------------------------------------------------------------------------------
// dmem_load_align
// Combinational load aligner: selects the addressed byte/half of a memory
// word, shifts it to bit 0 and sign- or zero-extends it.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  ofs_i,
    input  logic        unsigned_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and extension; word loads pass through untouched.
    always_comb begin
        byte_sel = word_i[{ofs_i, 3'b000} +: 8];
        half_sel = ofs_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_o  = '0;
        case (size_i)
            SIZE_B:  rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SIZE_H:  rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            SIZE_W:  rdata_o = word_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_bytectl.sv
//------------------------------------------------------------------------------
// dmem_bytectl
// Byte-addressed data memory with byte/half/word loads and stores, a
// post-reset clearing sweep, error flagging and a fixed-latency response
// pipeline. Optional store trace: define DMEM_TRACE_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_bytectl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int WIDX_W  = $clog2(DEPTH_WORDS);
    localparam int BYTE_AW = WIDX_W + 2;

    logic [31:0]       mem_q [DEPTH_WORDS];
    state_e            state_q;
    logic [WIDX_W-1:0] idx_q;
    logic              req_ready_q;

    logic              accept;
    logic              oor;
    logic              err;
    logic              do_write;
    logic [WIDX_W-1:0] widx;
    logic [1:0]        ofs;
    logic [3:0]        be;
    logic [31:0]       lanes;
    logic [31:0]       rd_word;

    stage_t            stage_d;
    stage_t            last_stage;
    logic [31:0]       aligned;

    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    assign accept   = req_valid & req_ready_q;
    assign widx     = req_addr[BYTE_AW-1:2];
    assign ofs      = req_addr[1:0];
    assign be       = byte_en(req_size, ofs);
    assign lanes    = lane_data(req_size, req_wdata);
    assign rd_word  = mem_q[widx];
    assign err      = is_misaligned(req_size, ofs) | oor;
    assign do_write = accept & req_we & ~err;

    // Any set address bit above the array span means out of range.
    generate
        if (ADDR_WIDTH > BYTE_AW) begin : g_rng
            assign oor = |req_addr[ADDR_WIDTH-1:BYTE_AW];
        end else begin : g_norng
            assign oor = 1'b0;
        end
    endgenerate

    // Init sweep then run; ready is registered and rises with the RUN state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INIT;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == WIDX_W'(DEPTH_WORDS - 1)) begin
                        state_q     <= RUN;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= RUN;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Memory array: cleared word-by-word during INIT, lane writes in RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == INIT) begin
                mem_q[idx_q] <= '0;
            end else if (do_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[widx][8*b +: 8] <= lanes[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef DMEM_TRACE_EN
    // One trace line per accepted store, showing the word before the write.
    always_ff @(posedge clock) begin
        if (!reset && accept && req_we) begin
            if (err) begin
                $display("%0t dmem ST ERR addr=%h size=%0d wdata=%h",
                         $time, req_addr, req_size, req_wdata);
            end else begin
                $display("%0t dmem ST addr=%h size=%0d wdata=%h old=%h",
                         $time, req_addr, req_size, req_wdata, rd_word);
            end
        end
    end
`endif

    // Pipeline entry built from the request and the word read at acceptance.
    always_comb begin
        stage_d       = '0;
        stage_d.valid = accept;
        stage_d.we    = req_we;
        stage_d.size  = req_size;
        stage_d.uns   = req_unsigned;
        stage_d.ofs   = ofs;
        stage_d.err   = err;
        stage_d.word  = accept ? rd_word : 32'd0;
    end

    // The output register is the last latency stage; extra stages sit ahead.
    generate
        if (LATENCY == 1) begin : g_lat1
            assign last_stage = stage_d;
        end else begin : g_latn
            stage_t pipe_q [LATENCY-1];

            // Shift register of in-flight responses, flushed by reset.
            always_ff @(posedge clock) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= stage_d;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign last_stage = pipe_q[LATENCY-2];
        end
    endgenerate

    dmem_load_align u_align (
        .word_i     (last_stage.word),
        .size_i     (last_stage.size),
        .ofs_i      (last_stage.ofs),
        .unsigned_i (last_stage.uns),
        .rdata_o    (aligned)
    );

    // Registered response; data forced to zero for stores and errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= last_stage.valid;
            rsp_err_q   <= last_stage.valid & last_stage.err;
            rsp_rdata_q <= (last_stage.valid & ~last_stage.err & ~last_stage.we) ? aligned : 32'd0;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bytectl.sv
//------------------------------------------------------------------------------
// tb_dmem_bytectl
// Directed bench driving two instances (LATENCY 1 and 3) with the same
// request stream; expected responses are queued with their due cycle.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_bytectl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy1, v1, e1;
    logic [31:0] d1;
    logic        rdy3, v3, e3;
    logic [31:0] d3;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_bytectl #(.DEPTH_WORDS(1024), .LATENCY(1), .ADDR_WIDTH(32)) u_dut1 (
        .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1)
    );

    dmem_bytectl #(.DEPTH_WORDS(1024), .LATENCY(3), .ADDR_WIDTH(32)) u_dut3 (
        .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor: at each falling edge either the queue head is due
    // and must match, or rsp_valid must be low.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q1.size() != 0 && q1[0].due == cyc) begin
                chk("l1_valid", 32'(v1), 32'd1);
                chk("l1_rdata", d1, q1[0].rd);
                chk("l1_err",   32'(e1), 32'(q1[0].err));
                void'(q1.pop_front());
            end else begin
                chk("l1_idle", 32'(v1), 32'd0);
            end
            if (q3.size() != 0 && q3[0].due == cyc) begin
                chk("l3_valid", 32'(v3), 32'd1);
                chk("l3_rdata", d3, q3[0].rd);
                chk("l3_err",   32'(e3), 32'(q3[0].err));
                void'(q3.pop_front());
            end else begin
                chk("l3_idle", 32'(v3), 32'd0);
            end
        end
    end

    // Present one request for one cycle; called at a falling edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.due = cyc + 1;
        q1.push_back(e);
        e.due = cyc + 3;
        q3.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Count falling edges with ready low; the init sweep must take 1024.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (rdy1 == 1'b0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, 1024);
        chk({tag, "_rdy3"}, 32'(rdy3), 32'd1);
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q3", q3.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_ready1", 32'(rdy1), 32'd0);
        chk("rst_valid1", 32'(v1),   32'd0);
        chk("rst_rdata1", d1,        32'd0);
        chk("rst_err1",   32'(e1),   32'd0);
        chk("rst_ready3", 32'(rdy3), 32'd0);
        chk("rst_valid3", 32'(v3),   32'd0);
        chk("rst_rdata3", d3,        32'd0);
        chk("rst_err3",   32'(e3),   32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        wait_init("init_len");

        // cleared top word
        issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h0000_0000, 1'b0);

        // extension cases
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
        issue(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);

        // partial store merge, back-to-back
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 32'h0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122_AA44, 1'b0);

        // upper half store and reads
        issue(1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF_8001, 32'h0, 1'b0);
        issue(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 32'hFFFF_8001, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, 32'hFFFF_FF80, 1'b0);
        issue(1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 32'h0000_0001, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h8001_0000, 1'b0);

        // error cases; none may write
        issue(1'b0, 2'd2, 1'b0, 32'h22,   32'h0,         32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h05,   32'h0,         32'h0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h00,   32'h0,         32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFE_F00D, 32'h0, 1'b1);
        issue(1'b1, 2'd2, 1'b0, 32'h02,   32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h01,   32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b1, 2'd3, 1'b0, 32'h00,   32'hFFFF_FFFF, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h00,   32'h0,         32'h0000_0000, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0);
        drain();

        // four loads back-to-back, then reset with two still in flight in the
        // LATENCY=3 instance; those must never appear
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1122_AA44, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h8001_0000, 1'b0);
        rst = 1'b1;
        while (q3.size() > 0 && q3[q3.size()-1].due > cyc) begin
            void'(q3.pop_back());
        end
        @(negedge clk);
        chk("mid_rst_ready", 32'(rdy1), 32'd0);
        rst = 1'b0;
        wait_init("reinit_len");

        // memory re-cleared
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_bytectl.md
Name: dmem_bytectl

Overview:
Parametrised, byte-addressed data memory for the core's MEM stage. Supports byte, halfword and word loads and stores, with sign or zero extension on loads. Requests use a valid/ready handshake and responses arrive after a fixed, configurable read latency. After reset an init sweep clears the array, and misaligned or out-of-range accesses are flagged rather than executed.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, minimum 16.
LATENCY, 1, response latency in cycles after the accepting edge; legal range 1..4.
ADDR_WIDTH, 32, width of the byte address port.

Ports:
clock  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  32  store data, taken from the low-order bits.
rsp_valid  out  1  response present; one-cycle pulse per accepted request.
rsp_rdata  out  32  extended load data; 0 for stores and for errors.
rsp_err  out  1  request was misaligned, out of range, or illegal size.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All pipeline stages are flushed; FSM goes to INIT with the sweep index at 0.
- FSM INIT:
  - Writes 0 to word[idx] each cycle, then increments idx.
  - After the write to word DEPTH_WORDS-1, moves to RUN. INIT lasts exactly DEPTH_WORDS cycles.
  - req_ready=0 throughout INIT.
  - Reset asserted mid-INIT restarts the sweep at idx 0.
- FSM RUN: req_ready=1 every cycle; no backpressure on responses. Stays in RUN until reset.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. Back-to-back accepts are allowed, one per cycle.
- Error check, evaluated at accept:
  - half access with addr[0]=1 is an error;
  - word access with addr[1:0]!=0 is an error;
  - req_size=3 is an error;
  - byte address >= DEPTH_WORDS*4 is an error.
  - An errored request performs no write. Its response carries rsp_err=1 and rsp_rdata=0.
- Store: writes the selected byte lanes of word addr[..:2] on the accepting edge. Lane selection is by size and addr[1:0]; unselected bytes are unchanged.
- Load: reads the word on the accepting edge. A store accepted at edge k is visible to a load accepted at edge k+1 or later.
- Load data:
  - The result is the addressed byte or half, shifted to bit 0, then sign- or zero-extended per req_unsigned.
  - Word loads ignore req_unsigned.
- Response pipeline:
  - Stages carry {valid, we, size, unsigned, addr[1:0], err, word}.
  - rsp_valid, rsp_rdata and rsp_err are registered outputs.
  - Timing: for a request accepted at edge k, the outputs are high during the cycle following edge k+LATENCY-1. With LATENCY=1 they are valid in the cycle right after acceptance.
  - Responses are returned in acceptance order.
- Reset mid-flight: in-flight responses are discarded and never emitted. Memory is re-cleared by INIT.
- Address bits above log2(DEPTH_WORDS*4) only contribute to the range check.

Optional Feature:
DMEM_TRACE_EN. When defined, each accepted store prints one line at the accepting edge: time, byte address, size, write data, and the old word value. Errored requests print with an ERR tag. When not defined, no $display is compiled and the RTL is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - the size enum (SIZE_B=2'd0, SIZE_H=2'd1, SIZE_W=2'd2);
  - the FSM state enum (INIT, RUN);
  - the pipeline-stage struct;
  - byte-enable generation and misalignment-check functions.
- One sub-module: dmem_load_align, combinational. It performs byte/half selection and extension from {word, size, addr[1:0], unsigned}. It is instanced at the last pipeline stage.

Test Plan:
- Reset, hold 1 cycle, release -> req_ready=0 for exactly 1024 cycles, then 1; a load of 0x3FC returns 0x00000000, rsp_err=0.
- SW 0xDEADBEEF @0x10, then LB @0x13 / LBU @0x13 / LH @0x12 / LHU @0x10 -> 0xFFFFFFDE / 0x000000DE / 0xFFFFDEAD / 0x0000BEEF, each appearing LATENCY cycles after its accept.
- SW 0x11223344 @0x20, then SB 0xAA @0x21, then LW @0x20 issued back-to-back -> 0x1122AA44; a store response has rsp_valid=1, rsp_rdata=0.
- LW @0x22, LH @0x05, req_size=3 @0x0, SW @0x1000 -> rsp_err=1 on all four; a subsequent LW @0x0 returns the unchanged 0x00000000.
- LATENCY=3 build: 4 loads on consecutive cycles -> 4 in-order rsp_valid pulses starting 3 cycles after the first accept; assert reset while 2 are in flight -> no further rsp_valid, INIT restarts.
- With DMEM_TRACE_EN defined -> exactly one trace line per accepted store; without it -> zero lines.
